// File: rtl/mips_ctrl_alu_unit.sv
// rtl/mips_ctrl_alu_unit.sv - ID/EX main decoder, ALU control and 32-bit ALU with one registered output stage
// Optional immediate ALU ops (addi/andi/ori) are enabled with macro IMM_ALU_OPS_EN.
module mips_ctrl_alu_unit #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [31:0]       inst,
   input  logic [DATA_W-1:0] rs_data,
   input  logic [DATA_W-1:0] rt_data,
   output logic              out_valid,
   output logic              reg_dst,
   output logic              alu_src,
   output logic              mem_to_reg,
   output logic              reg_write,
   output logic              mem_read,
   output logic              mem_write,
   output logic              branch,
   output logic              jump,
   output logic [1:0]        alu_op,
   output logic [3:0]        alu_ctr,
   output logic [DATA_W-1:0] alu_res,
   output logic              zero,
   output logic [4:0]        write_reg,
   output logic [DATA_W-1:0] store_data
);

   logic [5:0]        w_opcode;
   logic [5:0]        w_funct;
   logic              w_reg_dst;
   logic              w_alu_src;
   logic              w_mem_to_reg;
   logic              w_reg_write;
   logic              w_mem_read;
   logic              w_mem_write;
   logic              w_branch;
   logic              w_jump;
   logic [1:0]        w_alu_op;
   logic [3:0]        w_imm_ctr;
   logic              w_zext;
   logic [3:0]        w_alu_ctr;
   logic [DATA_W-1:0] w_imm_ext;
   logic [DATA_W-1:0] w_opb;
   logic [DATA_W-1:0] w_res;
   logic              w_slt;
   logic [4:0]        w_write_reg;
   logic              w_unused;

   logic              r_out_valid;
   logic              r_reg_dst;
   logic              r_alu_src;
   logic              r_mem_to_reg;
   logic              r_reg_write;
   logic              r_mem_read;
   logic              r_mem_write;
   logic              r_branch;
   logic              r_jump;
   logic [1:0]        r_alu_op;
   logic [3:0]        r_alu_ctr;
   logic [DATA_W-1:0] r_alu_res;
   logic              r_zero;
   logic [4:0]        r_write_reg;
   logic [DATA_W-1:0] r_store_data;

   assign w_opcode = inst[31:26];
   assign w_funct  = inst[5:0];
   assign w_unused = &{inst[25:21], inst[10:6]};

   always_comb begin
      w_reg_dst    = 1'b0;
      w_alu_src    = 1'b0;
      w_mem_to_reg = 1'b0;
      w_reg_write  = 1'b0;
      w_mem_read   = 1'b0;
      w_mem_write  = 1'b0;
      w_branch     = 1'b0;
      w_jump       = 1'b0;
      w_alu_op     = 2'b00;
      w_imm_ctr    = 4'b0010;
      w_zext       = 1'b0;
      case (w_opcode)
         6'b000000: begin
            w_reg_dst   = 1'b1;
            w_reg_write = 1'b1;
            w_alu_op    = 2'b10;
         end
         6'b100011: begin
            w_alu_src    = 1'b1;
            w_mem_to_reg = 1'b1;
            w_reg_write  = 1'b1;
            w_mem_read   = 1'b1;
         end
         6'b101011: begin
            w_alu_src   = 1'b1;
            w_mem_write = 1'b1;
         end
         6'b000100: begin
            w_branch = 1'b1;
            w_alu_op = 2'b01;
         end
         6'b000010: w_jump = 1'b1;
`ifdef IMM_ALU_OPS_EN
         6'b001000: begin
            w_alu_src   = 1'b1;
            w_reg_write = 1'b1;
            w_alu_op    = 2'b11;
            w_imm_ctr   = 4'b0010;
         end
         6'b001100: begin
            w_alu_src   = 1'b1;
            w_reg_write = 1'b1;
            w_alu_op    = 2'b11;
            w_imm_ctr   = 4'b0000;
            w_zext      = 1'b1;
         end
         6'b001101: begin
            w_alu_src   = 1'b1;
            w_reg_write = 1'b1;
            w_alu_op    = 2'b11;
            w_imm_ctr   = 4'b0001;
            w_zext      = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   always_comb begin
      w_alu_ctr = 4'b0010;
      case (w_alu_op)
         2'b00: w_alu_ctr = 4'b0010;
         2'b01: w_alu_ctr = 4'b0110;
         2'b10: begin
            case (w_funct)
               6'b100000: w_alu_ctr = 4'b0010;
               6'b100010: w_alu_ctr = 4'b0110;
               6'b100100: w_alu_ctr = 4'b0000;
               6'b100101: w_alu_ctr = 4'b0001;
               6'b101010: w_alu_ctr = 4'b0111;
               6'b100111: w_alu_ctr = 4'b1100;
               default:   w_alu_ctr = 4'b1111;
            endcase
         end
         default: w_alu_ctr = w_imm_ctr;
      endcase
   end

   // Logical immediates are zero-extended; everything else sign-extends.
   assign w_imm_ext = w_zext ? {{(DATA_W-16){1'b0}}, inst[15:0]}
                             : {{(DATA_W-16){inst[15]}}, inst[15:0]};
   assign w_opb     = w_alu_src ? w_imm_ext : rt_data;
   assign w_slt     = $signed(rs_data) < $signed(w_opb);

   always_comb begin
      w_res = '0;
      case (w_alu_ctr)
         4'b0000: w_res = rs_data & w_opb;
         4'b0001: w_res = rs_data | w_opb;
         4'b0010: w_res = rs_data + w_opb;
         4'b0110: w_res = rs_data - w_opb;
         4'b0111: w_res = {{(DATA_W-1){1'b0}}, w_slt};
         4'b1100: w_res = ~(rs_data | w_opb);
         default: w_res = '0;
      endcase
   end

   assign w_write_reg = w_reg_dst ? inst[15:11] : inst[20:16];

   // Bubbles clear control only; datapath outputs keep their last valid values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_out_valid  <= 1'b0;
         r_reg_dst    <= 1'b0;
         r_alu_src    <= 1'b0;
         r_mem_to_reg <= 1'b0;
         r_reg_write  <= 1'b0;
         r_mem_read   <= 1'b0;
         r_mem_write  <= 1'b0;
         r_branch     <= 1'b0;
         r_jump       <= 1'b0;
         r_alu_op     <= 2'b00;
         r_alu_ctr    <= 4'b0000;
         r_alu_res    <= '0;
         r_zero       <= 1'b0;
         r_write_reg  <= 5'd0;
         r_store_data <= '0;
      end else if (in_valid) begin
         r_out_valid  <= 1'b1;
         r_reg_dst    <= w_reg_dst;
         r_alu_src    <= w_alu_src;
         r_mem_to_reg <= w_mem_to_reg;
         r_reg_write  <= w_reg_write;
         r_mem_read   <= w_mem_read;
         r_mem_write  <= w_mem_write;
         r_branch     <= w_branch;
         r_jump       <= w_jump;
         r_alu_op     <= w_alu_op;
         r_alu_ctr    <= w_alu_ctr;
         r_alu_res    <= w_res;
         r_zero       <= (w_res == '0);
         r_write_reg  <= w_write_reg;
         r_store_data <= rt_data;
      end else begin
         r_out_valid  <= 1'b0;
         r_reg_dst    <= 1'b0;
         r_alu_src    <= 1'b0;
         r_mem_to_reg <= 1'b0;
         r_reg_write  <= 1'b0;
         r_mem_read   <= 1'b0;
         r_mem_write  <= 1'b0;
         r_branch     <= 1'b0;
         r_jump       <= 1'b0;
         r_alu_op     <= 2'b00;
         r_alu_ctr    <= 4'b0000;
      end
   end

   assign out_valid  = r_out_valid;
   assign reg_dst    = r_reg_dst;
   assign alu_src    = r_alu_src;
   assign mem_to_reg = r_mem_to_reg;
   assign reg_write  = r_reg_write;
   assign mem_read   = r_mem_read;
   assign mem_write  = r_mem_write;
   assign branch     = r_branch;
   assign jump       = r_jump;
   assign alu_op     = r_alu_op;
   assign alu_ctr    = r_alu_ctr;
   assign alu_res    = r_alu_res;
   assign zero       = r_zero;
   assign write_reg  = r_write_reg;
   assign store_data = r_store_data;

endmodule

// File: tb/tb_mips_ctrl_alu_unit.sv
// tb/tb_mips_ctrl_alu_unit.sv - directed vector table plus randomized reference-model checks for mips_ctrl_alu_unit
module tb_mips_ctrl_alu_unit;

   typedef struct {
      logic        valid;
      logic [7:0]  ctrl;   // {reg_dst,alu_src,mem_to_reg,reg_write,mem_read,mem_write,branch,jump}
      logic [1:0]  op;
      logic [3:0]  ctr;
      logic [31:0] res;
      logic        zero;
      logic [4:0]  wr;
      logic [31:0] sd;
   } exp_t;

   typedef struct {
      string       name;
      logic [31:0] inst;
      logic [31:0] rs;
      logic [31:0] rt;
      exp_t        e;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] inst = '0;
   logic [31:0] rs_data = '0;
   logic [31:0] rt_data = '0;
   logic        out_valid, reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, jump;
   logic [1:0]  alu_op;
   logic [3:0]  alu_ctr;
   logic [31:0] alu_res;
   logic        zero;
   logic [4:0]  write_reg;
   logic [31:0] store_data;

   int n_tests = 0;
   int n_fail  = 0;

   mips_ctrl_alu_unit #(.DATA_W(32)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .inst(inst),
      .rs_data(rs_data), .rt_data(rt_data), .out_valid(out_valid),
      .reg_dst(reg_dst), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
      .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
      .branch(branch), .jump(jump), .alu_op(alu_op), .alu_ctr(alu_ctr),
      .alu_res(alu_res), .zero(zero), .write_reg(write_reg), .store_data(store_data)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [7:0] ctrl, input logic [1:0] op, input logic [3:0] ctr,
                               input logic [31:0] res, input logic z, input logic [4:0] wr,
                               input logic [31:0] sd);
      exp_t e;
      e.valid = 1'b1; e.ctrl = ctrl; e.op = op; e.ctr = ctr;
      e.res = res; e.zero = z; e.wr = wr; e.sd = sd;
      return e;
   endfunction

   // Reference model: instruction semantics computed directly from the ISA rules.
   function automatic exp_t model(input logic [31:0] in, input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      logic [31:0] opb;
      logic [31:0] sext;
      logic [31:0] zext;
      sext = {{16{in[15]}}, in[15:0]};
      zext = {16'd0, in[15:0]};
      e.valid = 1'b1; e.ctrl = 8'h00; e.op = 2'd0; e.ctr = 4'd2; opb = b;
      case (in[31:26])
         6'd0: begin
            e.ctrl = 8'b1001_0000; e.op = 2'd2;
            case (in[5:0])
               6'h20: e.ctr = 4'h2;
               6'h22: e.ctr = 4'h6;
               6'h24: e.ctr = 4'h0;
               6'h25: e.ctr = 4'h1;
               6'h2A: e.ctr = 4'h7;
               6'h27: e.ctr = 4'hC;
               default: e.ctr = 4'hF;
            endcase
         end
         6'd35: begin e.ctrl = 8'b0111_1000; opb = sext; end
         6'd43: begin e.ctrl = 8'b0100_0100; opb = sext; end
         6'd4:  begin e.ctrl = 8'b0000_0010; e.op = 2'd1; e.ctr = 4'h6; end
         6'd2:  e.ctrl = 8'b0000_0001;
`ifdef IMM_ALU_OPS_EN
         6'd8:  begin e.ctrl = 8'b0101_0000; e.op = 2'd3; e.ctr = 4'h2; opb = sext; end
         6'd12: begin e.ctrl = 8'b0101_0000; e.op = 2'd3; e.ctr = 4'h0; opb = zext; end
         6'd13: begin e.ctrl = 8'b0101_0000; e.op = 2'd3; e.ctr = 4'h1; opb = zext; end
`endif
         default: ;
      endcase
      case (e.ctr)
         4'h0: e.res = a & opb;
         4'h1: e.res = a | opb;
         4'h2: e.res = a + opb;
         4'h6: e.res = a - opb;
         4'h7: e.res = ($signed(a) < $signed(opb)) ? 32'd1 : 32'd0;
         4'hC: e.res = ~(a | opb);
         default: e.res = 32'd0;
      endcase
      e.zero = (e.res == 32'd0);
      e.wr   = e.ctrl[7] ? in[15:11] : in[20:16];
      e.sd   = b;
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic chk_all(input string tag, input exp_t e);
      chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, e.valid});
      chk({tag, ".ctrl"}, {24'd0, reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, jump},
          {24'd0, e.ctrl});
      chk({tag, ".alu_op"}, {30'd0, alu_op}, {30'd0, e.op});
      chk({tag, ".alu_ctr"}, {28'd0, alu_ctr}, {28'd0, e.ctr});
      chk({tag, ".alu_res"}, alu_res, e.res);
      chk({tag, ".zero"}, {31'd0, zero}, {31'd0, e.zero});
      chk({tag, ".write_reg"}, {27'd0, write_reg}, {27'd0, e.wr});
      chk({tag, ".store_data"}, store_data, e.sd);
   endtask

   task automatic apply(input logic v, input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      in_valid = v; inst = i; rs_data = a; rt_data = b;
      @(posedge clk);
      #1;
   endtask

   exp_t zero_e;
   exp_t held;
   vec_t vecs[$];

   initial begin
      zero_e = mk(8'h00, 2'd0, 4'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      zero_e.valid = 1'b0;

      vecs.push_back('{"add",   32'h00221820, 32'd5, 32'd7,
                     mk(8'b1001_0000, 2'd2, 4'h2, 32'd12, 1'b0, 5'd3, 32'd7)});
      vecs.push_back('{"slt",   32'h0022182A, 32'hFFFFFFFF, 32'd1,
                     mk(8'b1001_0000, 2'd2, 4'h7, 32'd1, 1'b0, 5'd3, 32'd1)});
      vecs.push_back('{"sub0",  32'h00221822, 32'd9, 32'd9,
                     mk(8'b1001_0000, 2'd2, 4'h6, 32'd0, 1'b1, 5'd3, 32'd9)});
      vecs.push_back('{"lw",    32'h8C22FFFC, 32'd100, 32'd55,
                     mk(8'b0111_1000, 2'd0, 4'h2, 32'd96, 1'b0, 5'd2, 32'd55)});
      vecs.push_back('{"sw",    32'hAC220008, 32'd100, 32'hDEADBEEF,
                     mk(8'b0100_0100, 2'd0, 4'h2, 32'd108, 1'b0, 5'd2, 32'hDEADBEEF)});
      vecs.push_back('{"j",     32'h08000010, 32'd3, 32'd4,
                     mk(8'b0000_0001, 2'd0, 4'h2, 32'd7, 1'b0, 5'd0, 32'd4)});
      vecs.push_back('{"unk",   32'hFC221234, 32'd1, 32'd2,
                     mk(8'h00, 2'd0, 4'h2, 32'd3, 1'b0, 5'd2, 32'd2)});
      vecs.push_back('{"fn0",   32'h00221800, 32'd5, 32'd7,
                     mk(8'b1001_0000, 2'd2, 4'hF, 32'd0, 1'b1, 5'd3, 32'd7)});
      vecs.push_back('{"and",   32'h00221824, 32'h0000F0F0, 32'h0000FF00,
                     mk(8'b1001_0000, 2'd2, 4'h0, 32'h0000F000, 1'b0, 5'd3, 32'h0000FF00)});
      vecs.push_back('{"or",    32'h00221825, 32'h0000F0F0, 32'h0000FF00,
                     mk(8'b1001_0000, 2'd2, 4'h1, 32'h0000FFF0, 1'b0, 5'd3, 32'h0000FF00)});
      vecs.push_back('{"nor",   32'h00221827, 32'd0, 32'd0,
                     mk(8'b1001_0000, 2'd2, 4'hC, 32'hFFFFFFFF, 1'b0, 5'd3, 32'd0)});
      vecs.push_back('{"sltn",  32'h0022182A, 32'd1, 32'hFFFFFFFF,
                     mk(8'b1001_0000, 2'd2, 4'h7, 32'd0, 1'b1, 5'd3, 32'hFFFFFFFF)});
      vecs.push_back('{"subw",  32'h00221822, 32'd0, 32'd1,
                     mk(8'b1001_0000, 2'd2, 4'h6, 32'hFFFFFFFF, 1'b0, 5'd3, 32'd1)});
      vecs.push_back('{"addw",  32'h00221820, 32'hFFFFFFFF, 32'd2,
                     mk(8'b1001_0000, 2'd2, 4'h2, 32'd1, 1'b0, 5'd3, 32'd2)});
`ifdef IMM_ALU_OPS_EN
      vecs.push_back('{"ori",   32'h342280F0, 32'h00000F00, 32'd1,
                     mk(8'b0101_0000, 2'd3, 4'h1, 32'h00008FF0, 1'b0, 5'd2, 32'd1)});
`else
      vecs.push_back('{"ori",   32'h342280F0, 32'h00000F00, 32'd1,
                     mk(8'h00, 2'd0, 4'h2, 32'h00000F01, 1'b0, 5'd2, 32'd1)});
`endif

      #3;
      chk_all("reset", zero_e);
      @(negedge clk);
      reset = 1'b1;

      foreach (vecs[k]) begin
         apply(1'b1, vecs[k].inst, vecs[k].rs, vecs[k].rt);
         chk_all(vecs[k].name, vecs[k].e);
      end

      // beq then a bubble: control clears, datapath outputs hold.
      apply(1'b1, 32'h10220003, 32'd42, 32'd42);
      held = mk(8'b0000_0010, 2'd1, 4'h6, 32'd0, 1'b1, 5'd2, 32'd42);
      chk_all("beq", held);
      apply(1'b0, 32'h00221820, 32'd1, 32'd1);
      held.valid = 1'b0; held.ctrl = 8'h00; held.op = 2'd0; held.ctr = 4'd0;
      chk_all("bubble", held);

      // Asynchronous reset mid-cycle with in_valid high.
      apply(1'b1, 32'h00221820, 32'd5, 32'd7);
      @(negedge clk);
      in_valid = 1'b1;
      #2 reset = 1'b0;
      #1 chk_all("async_rst", zero_e);
      @(posedge clk);
      #1 chk_all("rst_hold", zero_e);
      @(negedge clk);
      reset = 1'b1;
      apply(1'b1, 32'h00221820, 32'd5, 32'd7);
      chk_all("post_rst", mk(8'b1001_0000, 2'd2, 4'h2, 32'd12, 1'b0, 5'd3, 32'd7));

      held = mk(8'b1001_0000, 2'd2, 4'h2, 32'd12, 1'b0, 5'd3, 32'd7);
      for (int n = 0; n < 400; n++) begin
         logic [5:0]  ops[8];
         logic [5:0]  fns[6];
         logic [31:0] ri, ra, rb;
         logic        rv;
         ops = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd2, 6'd8, 6'd12, 6'd13};
         fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};
         ri = $urandom;
         if ($urandom_range(0, 8) != 8) ri[31:26] = ops[$urandom_range(0, 7)];
         if ($urandom_range(0, 6) != 6) ri[5:0] = fns[$urandom_range(0, 5)];
         ra = $urandom;
         rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
         if ($urandom_range(0, 3) == 0) begin
            ra = $urandom_range(0, 20);
            rb = $urandom_range(0, 20);
         end
         rv = ($urandom_range(0, 4) != 0);
         apply(rv, ri, ra, rb);
         if (rv) held = model(ri, ra, rb);
         else begin
            held.valid = 1'b0; held.ctrl = 8'h00; held.op = 2'd0; held.ctr = 4'd0;
         end
         chk_all($sformatf("rnd%0d", n), held);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
